// File: rtl/pixel_stream_tx_pkg.sv
// Shared types and constants for the pixel nibble transmitter.
// State encoding, nibble indices and the packed pixel width used by pixel_fifo and pixel_stream_tx.
package pixel_stream_tx_pkg;

    localparam int PIXEL_W = 16;
    localparam int NIB_W   = 4;

    localparam logic [1:0] NIB_X_HI = 2'd0;
    localparam logic [1:0] NIB_X_LO = 2'd1;
    localparam logic [1:0] NIB_Y_HI = 2'd2;
    localparam logic [1:0] NIB_Y_LO = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/pixel_stream_tx_fifo.sv
// Synchronous FIFO for packed {x,y} pixels with registered pointers and an occupancy count.
// A push on a full FIFO is accepted only when a pop happens on the same edge.
module pixel_fifo
    import pixel_stream_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PIXEL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Buffers the drawing pixel stream and sends each pixel as four nibbles over a 4-phase req/ack link.
// Optional build macro PIXEL_DEDUP_EN discards a pixel identical to the last accepted one.
module pixel_stream_tx
    import pixel_stream_tx_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 pixel_x,
    input  logic [7:0]                 pixel_y,
    input  logic                       pixel_valid,
    output logic [3:0]                 tx_data,
    output logic                       tx_valid,
    output logic                       tx_first,
    input  logic                       tx_ack,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic                       idle
);

    tx_state_e              state_q, state_d;
    logic [1:0]             nib_q, nib_d;
    logic [PIXEL_W-1:0]     shift_q, shift_d;
    logic [NIB_W-1:0]       tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_first_q, tx_first_d;
    logic                   overflow_q, overflow_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_s;

    logic [PIXEL_W-1:0]     pixel_xy, fifo_rdata;
    logic                   push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                   dup, drop;

    assign pixel_xy  = {pixel_x, pixel_y};
    assign push_req  = pixel_valid && !dup;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

    pixel_fifo #(.DEPTH(DEPTH), .WIDTH(PIXEL_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (pixel_xy),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef PIXEL_DEDUP_EN
    logic [PIXEL_W-1:0] last_xy_q, last_xy_d;
    logic               last_vld_q, last_vld_d;

    assign dup = last_vld_q && (pixel_xy == last_xy_q);

    always_comb begin
        last_xy_d  = last_xy_q;
        last_vld_d = last_vld_q;
        if (fifo_push) begin
            last_xy_d  = pixel_xy;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_xy_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_xy_q  <= last_xy_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], tx_ack};
    assign ack_s      = ack_sync_q[SYNC_STAGES-1];

    // A drop on the same edge as a clear leaves the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_first_d = tx_first_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    tx_data_d  = fifo_rdata[PIXEL_W-1 -: NIB_W];
                    shift_d    = fifo_rdata << NIB_W;
                    tx_first_d = 1'b1;
                    tx_valid_d = 1'b1;
                    nib_d      = NIB_X_HI;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (ack_s) begin
                    tx_valid_d = 1'b0;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    tx_first_d = 1'b0;
                    if (nib_q != NIB_Y_LO) begin
                        nib_d      = nib_q + 2'd1;
                        tx_data_d  = shift_q[PIXEL_W-1 -: NIB_W];
                        shift_d    = shift_q << NIB_W;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            nib_q      <= NIB_X_HI;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_first_q <= 1'b0;
            overflow_q <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_first_q <= tx_first_d;
            overflow_q <= overflow_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_first = tx_first_q;
    assign overflow = overflow_q;
    assign idle     = (fifo_level == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Self-checking bench for pixel_stream_tx: directed vectors, burst/overflow/reset sequences,
// and a randomized run scored against a queue-based reference model (honours PIXEL_DEDUP_EN).
module tb_pixel_stream_tx;

    localparam int DEPTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LVL_W       = $clog2(DEPTH) + 1;
    localparam int NV          = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       pixel_x = '0, pixel_y = '0;
    logic             pixel_valid = 1'b0, clear_overflow = 1'b0;
    logic [3:0]       tx_data;
    logic             tx_valid, tx_first, tx_ack, overflow, idle;
    logic [LVL_W-1:0] fifo_level;

    always #5 clk = ~clk;

    pixel_stream_tx #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .pixel_valid    (pixel_valid),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_first       (tx_first),
        .tx_ack         (tx_ack),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .idle           (idle)
    );

    // External device model: acks after a programmable delay and reassembles pixels.
    logic resp_ack = 1'b0, ack_manual = 1'b0, ack_man = 1'b0, resp_en = 1'b1;
    int   resp_min = 1, resp_max = 1, resp_cnt = 0, resp_lim = 0, rx_nib = 0;
    logic [15:0] rx_word = '0;
    logic        rx_fok = 1'b0;

    typedef struct { logic [15:0] word; logic first_ok; } rx_t;
    rx_t rx_q[$];

    assign tx_ack = ack_manual ? ack_man : resp_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            resp_ack <= 1'b0;
            resp_cnt <= 0;
            rx_nib   <= 0;
        end else if (resp_en && (tx_valid != resp_ack)) begin
            if (resp_cnt == 0) begin
                resp_lim <= $urandom_range(resp_max, resp_min);
                resp_cnt <= 1;
            end else if (resp_cnt <= resp_lim) begin
                resp_cnt <= resp_cnt + 1;
            end else begin
                resp_cnt <= 0;
                resp_ack <= tx_valid;
                if (tx_valid) begin
                    rx_word <= {rx_word[11:0], tx_data};
                    if (rx_nib == 3) begin
                        rx_q.push_back('{word: {rx_word[11:0], tx_data}, first_ok: rx_fok && !tx_first});
                        rx_nib <= 0;
                    end else begin
                        rx_nib <= rx_nib + 1;
                        rx_fok <= (rx_nib == 0) ? tx_first : (rx_fok && !tx_first);
                    end
                end
            end
        end else begin
            resp_cnt <= 0;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(idle && !tx_ack && !tx_valid) && n < budget);
        check(name, idle, 1);
    endtask

    task automatic wait_rx(input string name, input int target, input int budget);
        int n = 0;
        while (rx_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, rx_q.size(), target);
    endtask

    task automatic drive_px(input logic [15:0] xy);
        @(negedge clk);
        pixel_x     = xy[15:8];
        pixel_y     = xy[7:0];
        pixel_valid = 1'b1;
    endtask

    task automatic end_px();
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    function automatic logic [15:0] mk_px(input logic [3:0] hi, input int i);
        return {4'(i), 4'h1, hi, 4'(i)};
    endfunction

    typedef struct {
        logic [7:0]  x, y;
        int          dly;
        int          exp_lat;
        logic [15:0] exp_word;
        logic [3:0]  exp_last;
    } vec_t;
    vec_t vecs[NV];

    logic [15:0] m_q[$];
    logic [15:0] dd_px[$], exp_dd[$];
    logic [15:0] m_last, xy;
    logic        m_last_vld, m_ovf, prev_valid, pop_seen, drop, dup, saw;
    logic        app_v, app_clr;
    logic [7:0]  app_x, app_y;
    int          m_count, base, lat, cnt;

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 3, 2, 16'hA53C, 4'hC};
        vecs[1] = '{8'h00, 8'h00, 0, 2, 16'h0000, 4'h0};
        vecs[2] = '{8'hFF, 8'hFF, 1, 2, 16'hFFFF, 4'hF};
        vecs[3] = '{8'h12, 8'h80, 4, 2, 16'h1280, 4'h0};
        vecs[4] = '{8'h7E, 8'h01, 2, 2, 16'h7E01, 4'h1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_first", tx_first, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;

        // Single pixels: latency, nibble order, tx_first placement, held data
        for (int i = 0; i < NV; i++) begin
            resp_min = vecs[i].dly;
            resp_max = vecs[i].dly;
            base = rx_q.size();
            drive_px({vecs[i].x, vecs[i].y});
            end_px();
            lat = 1;
            while (!tx_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_first_flag", i), tx_first, 1);
            check($sformatf("v%0d_first_nib", i), tx_data, vecs[i].exp_word[15:12]);
            wait_rx($sformatf("v%0d_rx_count", i), base + 1, 400);
            wait_idle($sformatf("v%0d_idle", i), 400);
            if (rx_q.size() > base) begin
                check($sformatf("v%0d_word", i), rx_q[base].word, vecs[i].exp_word);
                check($sformatf("v%0d_first_only_nib0", i), rx_q[base].first_ok, 1);
            end
            check($sformatf("v%0d_data_held", i), tx_data, vecs[i].exp_last);
        end

        // Burst of 10 with ack held low: one slot freed by the first pop, pixel #10 dropped
        resp_en = 1'b0;
        ack_manual = 1'b1;
        ack_man = 1'b0;
        for (int i = 0; i < 10; i++) drive_px(mk_px(4'h8, i));
        end_px();
        check("burst_level", fifo_level, DEPTH);
        check("burst_overflow", overflow, 1);
        check("burst_presenting", tx_valid, 1);
        check("burst_first_nib", tx_data, 0);

        // Clear on the same edge as a drop: drop wins
        drive_px(16'hEEEE);
        clear_overflow = 1'b1;
        @(negedge clk);
        pixel_valid = 1'b0;
        clear_overflow = 1'b0;
        check("clr_vs_drop_overflow", overflow, 1);
        check("clr_vs_drop_level", fifo_level, DEPTH);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("clr_alone_overflow", overflow, 0);

        // Release ack: pixels 0..8 delivered in order, nothing else
        base = rx_q.size();
        resp_min = 0;
        resp_max = 2;
        resp_en = 1'b1;
        ack_manual = 1'b0;
        wait_rx("burst_rx_count", base + 9, 3000);
        wait_idle("burst_idle", 500);
        check("burst_no_extra", rx_q.size(), base + 9);
        for (int k = 0; k < 9; k++)
            if (rx_q.size() > base + k)
                check($sformatf("burst_word%0d", k), rx_q[base + k].word, mk_px(4'h8, k));

        // Full FIFO with push and pop on the same edge
        resp_en = 1'b0;
        ack_manual = 1'b1;
        ack_man = 1'b0;
        for (int i = 0; i < 9; i++) drive_px(mk_px(4'hA, i));
        end_px();
        check("same_edge_prefill_level", fifo_level, DEPTH);
        for (int n = 0; n < 4; n++) begin
            ack_man = 1'b1;
            repeat (6) @(negedge clk);
            ack_man = 1'b0;
            if (n < 3) repeat (6) @(negedge clk);
        end
        // IDLE is reached SYNC_STAGES+1 edges after ack falls; the pop follows on the next edge
        repeat (SYNC_STAGES + 1) @(negedge clk);
        pixel_x = 8'hC3;
        pixel_y = 8'h5A;
        pixel_valid = 1'b1;
        end_px();
        check("same_edge_level", fifo_level, DEPTH);
        check("same_edge_overflow", overflow, 0);
        check("same_edge_popped", tx_valid, 1);
        check("same_edge_next_pixel", tx_data, 1);
        base = rx_q.size();
        resp_en = 1'b1;
        ack_manual = 1'b0;
        wait_rx("same_edge_rx_count", base + 9, 3000);
        wait_idle("same_edge_idle", 500);
        for (int k = 0; k < 9; k++)
            if (rx_q.size() > base + k)
                check($sformatf("same_edge_word%0d", k), rx_q[base + k].word,
                      (k < 8) ? mk_px(4'hA, k + 1) : 16'hC35A);

        // Reset while the third nibble is on the bus
        resp_min = 2;
        resp_max = 2;
        base = rx_q.size();
        drive_px(16'h1234);
        drive_px(16'h5678);
        drive_px(16'h9ABC);
        end_px();
        cnt = 0;
        while (!(tx_valid && !tx_first && tx_data == 4'h3) && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_mid_reached_nib2", tx_data, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_tx_valid", tx_valid, 0);
        check("rst_mid_tx_data", tx_data, 0);
        check("rst_mid_tx_first", tx_first, 0);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_idle", idle, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (tx_valid) saw = 1'b1;
        end
        check("rst_mid_no_stale", saw, 0);
        check("rst_mid_level_after", fifo_level, 0);
        check("rst_mid_no_rx", rx_q.size(), base);

        // Duplicate pixels
        resp_min = 1;
        resp_max = 1;
        base = rx_q.size();
        dd_px = '{16'h0505, 16'h0505, 16'h0605, 16'h0505};
`ifdef PIXEL_DEDUP_EN
        exp_dd = '{16'h0505, 16'h0605, 16'h0505};
`else
        exp_dd = '{16'h0505, 16'h0505, 16'h0605, 16'h0505};
`endif
        foreach (dd_px[i]) drive_px(dd_px[i]);
        end_px();
        wait_rx("dedup_rx_count", base + exp_dd.size(), 1000);
        wait_idle("dedup_idle", 500);
        check("dedup_exact_count", rx_q.size(), base + exp_dd.size());
        check("dedup_overflow", overflow, 0);
        foreach (exp_dd[k])
            if (rx_q.size() > base + k)
                check($sformatf("dedup_word%0d", k), rx_q[base + k].word, exp_dd[k]);

        // Randomized traffic against a reference model of the FIFO occupancy and accepted order
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_min = 0;
        resp_max = 3;
        base = rx_q.size();
        m_q.delete();
        m_count = 0;
        m_ovf = 1'b0;
        m_last = '0;
        m_last_vld = 1'b0;
        prev_valid = 1'b0;
        app_v = 1'b0;
        app_clr = 1'b0;
        app_x = '0;
        app_y = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            pop_seen = tx_valid && tx_first && !prev_valid;
            prev_valid = tx_valid;
            drop = 1'b0;
            if (app_v) begin
                xy = {app_x, app_y};
`ifdef PIXEL_DEDUP_EN
                dup = m_last_vld && (xy == m_last);
`else
                dup = 1'b0;
`endif
                if (!dup) begin
                    if (m_count < DEPTH || pop_seen) begin
                        m_q.push_back(xy);
                        m_count++;
                        m_last = xy;
                        m_last_vld = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            if (pop_seen) m_count--;
            if (drop) m_ovf = 1'b1;
            else if (app_clr) m_ovf = 1'b0;
            check("rnd_level", fifo_level, m_count);
            check("rnd_overflow", overflow, m_ovf);

            app_v   = ($urandom_range(99, 0) < ((cyc < 1000) ? 4 : 35)) && (cyc < 1999);
            app_clr = ($urandom_range(99, 0) < 3) && (cyc < 1999);
            if ($urandom_range(1, 0) == 1) begin
                app_x = 8'($urandom_range(3, 0));
                app_y = 8'($urandom_range(1, 0));
            end else begin
                app_x = 8'($urandom);
                app_y = 8'($urandom);
            end
            pixel_x        = app_x;
            pixel_y        = app_y;
            pixel_valid    = app_v;
            clear_overflow = app_clr;
        end
        pixel_valid = 1'b0;
        clear_overflow = 1'b0;
        wait_rx("rnd_rx_count", base + m_q.size(), 3000);
        wait_idle("rnd_idle", 500);
        foreach (m_q[k])
            if (rx_q.size() > base + k) begin
                check($sformatf("rnd_word%0d", k), rx_q[base + k].word, m_q[k]);
                check($sformatf("rnd_first%0d", k), rx_q[base + k].first_ok, 1);
            end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
